uoram_frontend_ctrl: RTL and testbench
======================================

# uoram_frontend_ctrl

Unified ORAM frontend control block. It accepts (cmd, addr, mask) requests from the network and walks the recursive PosMap through an external PosMap PLB until a lookup hits. It then issues backend commands in reverse order, with PLB refills and evictions in between. It sits between the network request port, the PosMap PLB, the backend command port and the frontend data-path scheduler.

## Interface
Parameters:
- ORAMU, 32: block address width.
- NumValidBlock, 1024: number of program data blocks. PosMap block addresses start here.
- LeafInBlock, 16: PosMap entries per block.
- Recursion, 3: PosMap levels including the data level. Maximum 16.
- EnablePLB, 1: 0 forces misses to mimic non-PLB recursive ORAM.
- BECMDWidth, 2 and DMWidth, 8: command and mask widths.

Ports:
- Clock  in  1  sole clock.
- Reset  in  1  asynchronous, active-low.
- CmdInReady/CmdInValid  out/in  1  request handshake.
- CmdIn  in  BECMDWidth.
- ProgAddrIn  in  ORAMU.
- WMaskIn  in  DMWidth.
- PPPCmdReady  in  1.
- PPPCmdValid  out  1.
- PPPCmd  out  2.
- PPPAddrIn  out  ORAMU.
- PPPRefill  out  1  PLB data-in valid.
- PPPValid, PPPHit, PPPUnInit, PPPEvict  in  1  PLB result.
- PPPAddrOut  in  ORAMU  evicted entry address.
- PPPOutReady  out  1  consumes the PLB result.
- PPPRefillDataValid, PPPEvictDataEmpty  in  1  from the data path.
- CmdOutReady/CmdOutValid  in/out  1  backend handshake.
- CmdOut  out  BECMDWidth.
- AddrOut  out  ORAMU.
- WMaskOut  out  DMWidth.
- SwitchReq, DataBlockReq, InitRequest  out  1  to the data path.
- ExpectingProgramData, FakeAccess  in  1  from the data path.
- ErrorOutOfRange  out  1  sticky error.

Encodings:
- BECMD_Append = 1, BECMD_ReadRmv = 3.
- CacheWrite = 0, CacheRead = 1, CacheRefill = 2, CacheInitRefill = 3.

## Operation
- State is held in flags Preparing, Accessing, RefillStarted, InitRefill and Lookup, plus QDepth and the address queue AddrQ[0..Recursion-1]. All reset to 0.
- PPPMiss = PPPValid && (!PPPHit || FakeMiss).
- FakeMiss = !EnablePLB && Preparing && PPPValid && QDepth < Recursion-1.
- UnInit = PPPValid && PPPHit && PPPUnInit.
- Idle: CmdInReady = !Preparing && !Accessing && !ExpectingProgramData && PPPCmdReady && !FakeAccess.
- On request accept:
  - Capture CmdIn and WMaskIn as LastCmd and LastMask.
  - Set QDepth = 0 and AddrQ[0] = ProgAddrIn.
  - Set Preparing and Lookup.
- Preparing:
  - On PPPMiss: set AddrQ[QDepth+1] = NumValidBlock + AddrQ[QDepth]/LeafInBlock and increment QDepth. Lookup stays 1 for the next query.
  - On a PLB result that is not a miss: clear Preparing and set Accessing.
- Accessing:
  - CmdOutValid = PPPValid && !ErrorOutOfRange && ((PPPHit && !PPPUnInit) || InitRequest || PPPEvict).
  - DataBlockReq = (QDepth == 0).
  - InitRequest = DataBlockReq && UnInit.
  - CmdOut is BECMD_Append for an eviction or init request. Otherwise it is LastCmd when DataBlockReq, else BECMD_ReadRmv.
  - WMaskOut is LastMask only for a non-evict, non-init data request. Otherwise it is 0.
  - AddrOut is NumValidBlock + PPPAddrOut/LeafInBlock on an eviction. Otherwise it is AddrQ[QDepth].
  - SwitchReq = (CmdOut fire && !PPPEvict) || (!DataBlockReq && UnInit).
  - On SwitchReq: decrement QDepth.
  - On SwitchReq with DataBlockReq: clear Accessing.
  - An eviction fire does not advance QDepth.
- PLB port:
  - PPPRefill = Accessing && (PPPRefillDataValid || InitRefill).
  - PPPCmdValid = Lookup || (PPPRefill && !RefillStarted).
  - PPPCmd is CacheInitRefill or CacheRefill while refilling. Otherwise it is CacheRead if (Preparing && !EnablePLB && QDepth < Recursion-1), else CacheWrite.
  - PPPAddrIn = AddrQ[QDepth].
  - PPPOutReady is PPPMiss while Preparing. Otherwise it is (PPPMiss && !PPPEvict) || (UnInit && QDepth > 0) || CmdOutReady.
- Flags:
  - RefillStarted is set by PPPRefill && PPPCmdReady and cleared by SwitchReq.
  - InitRefill is set after SwitchReq on an uninitialised PosMap block and cleared by InitRefill && PPPCmdReady.
  - Lookup next value is PPPMiss while Preparing. Otherwise it is RefillStarted && PPPCmdReady && PPPEvictDataEmpty. Lookup is cleared by Accessing && SwitchReq.
- Priority: every flag's clear condition beats its set condition.

## Timing
- All state is registered, with a single clock edge per update.
- Outputs are combinational from state and inputs.
- Accept to first PPPCmdValid: 1 cycle.
- Each PLB miss to the next lookup: 1 cycle.
- Backend command fires on the same cycle that CmdOutReady && CmdOutValid.
- An asynchronous reset mid-operation returns the block to idle immediately.

## Configuration
UORAM_RANGE_CHECK_EN:
- When defined, an accepted address ≥ NumValidBlock sets ErrorOutOfRange. It is sticky until reset and blocks CmdOutValid.
- When undefined, ErrorOutOfRange is tied to 0 and no check is made.

## Test plan
- Reset, then hold PPPCmdReady=1 with ExpectingProgramData=FakeAccess=0. Required: CmdInReady=1 and all valids=0.
- Address 5, first lookup hits. Required:
  - PPPCmd=CacheWrite and PPPAddrIn=5.
  - CmdOut=LastCmd and AddrOut=5.
  - SwitchReq fires, then the block returns to idle.
- Address 40, first lookup misses. Required:
  - Second lookup at address 1026, which hits.
  - CmdOut=ReadRmv at address 1026, then a refill, then the data command at address 40.
- Eviction with PPPAddrOut=48. Required: CmdOut=Append, AddrOut=1027, QDepth unchanged.
- Address 1024 with UORAM_RANGE_CHECK_EN defined. Required: ErrorOutOfRange=1 and CmdOutValid never asserts.
- EnablePLB=0 with every lookup hitting. Required: 3 lookups (CacheRead, CacheRead, CacheWrite), then the access sequence.

Source files
------------

// File: rtl/uoram_frontend_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : uoram_frontend_ctrl
// Brief    : Unified ORAM frontend control. Walks the recursive PosMap through
//            the PLB, then issues backend commands in reverse order.
//            Optional: define UORAM_RANGE_CHECK_EN for sticky out-of-range error.
// Revision : 1.0 - initial release
// ============================================================================
module uoram_frontend_ctrl #(
    parameter int ORAMU           = 32,
    parameter int NUM_VALID_BLOCK = 1024,
    parameter int LEAF_IN_BLOCK   = 16,
    parameter int RECURSION       = 3,
    parameter int ENABLE_PLB      = 1,
    parameter int BECMD_WIDTH     = 2,
    parameter int DM_WIDTH        = 8
) (
    input  logic                   clk,
    input  logic                   rst_n,
    output logic                   o_CmdInReady,
    input  logic                   i_CmdInValid,
    input  logic [BECMD_WIDTH-1:0] i_CmdIn,
    input  logic [ORAMU-1:0]       i_ProgAddrIn,
    input  logic [DM_WIDTH-1:0]    i_WMaskIn,
    input  logic                   i_PPPCmdReady,
    output logic                   o_PPPCmdValid,
    output logic [1:0]             o_PPPCmd,
    output logic [ORAMU-1:0]       o_PPPAddrIn,
    output logic                   o_PPPRefill,
    input  logic                   i_PPPValid,
    input  logic                   i_PPPHit,
    input  logic                   i_PPPUnInit,
    input  logic                   i_PPPEvict,
    input  logic [ORAMU-1:0]       i_PPPAddrOut,
    output logic                   o_PPPOutReady,
    input  logic                   i_PPPRefillDataValid,
    input  logic                   i_PPPEvictDataEmpty,
    input  logic                   i_CmdOutReady,
    output logic                   o_CmdOutValid,
    output logic [BECMD_WIDTH-1:0] o_CmdOut,
    output logic [ORAMU-1:0]       o_AddrOut,
    output logic [DM_WIDTH-1:0]    o_WMaskOut,
    output logic                   o_SwitchReq,
    output logic                   o_DataBlockReq,
    output logic                   o_InitRequest,
    input  logic                   i_ExpectingProgramData,
    input  logic                   i_FakeAccess,
    output logic                   o_ErrorOutOfRange
);

    localparam int QW = (RECURSION > 1) ? $clog2(RECURSION) : 1;
    localparam logic [QW-1:0]          c_qmax          = QW'(RECURSION - 1);
    localparam logic [ORAMU-1:0]       c_nvb           = ORAMU'(NUM_VALID_BLOCK);
    localparam logic [ORAMU-1:0]       c_lib           = ORAMU'(LEAF_IN_BLOCK);
    localparam logic                   c_plb_off       = (ENABLE_PLB == 0);
    localparam logic [BECMD_WIDTH-1:0] c_becmd_append  = BECMD_WIDTH'(1);
    localparam logic [BECMD_WIDTH-1:0] c_becmd_readrmv = BECMD_WIDTH'(3);
    localparam logic [1:0] c_cache_write      = 2'd0;
    localparam logic [1:0] c_cache_read       = 2'd1;
    localparam logic [1:0] c_cache_refill     = 2'd2;
    localparam logic [1:0] c_cache_initrefill = 2'd3;

    logic                   r_preparing, r_accessing, r_refill_started;
    logic                   r_init_refill, r_lookup;
    logic [QW-1:0]          r_qdepth;
    logic [ORAMU-1:0]       r_addrq [RECURSION];
    logic [BECMD_WIDTH-1:0] r_last_cmd;
    logic [DM_WIDTH-1:0]    r_last_mask;

    logic w_fake_miss, w_miss, w_uninit, w_accept, w_dbr, w_init_req;
    logic w_fire, w_switch, w_refill, w_below_top, w_err;
    logic [QW-1:0]    w_qinc;
    logic [ORAMU-1:0] w_cur_addr;

    assign w_below_top = r_qdepth < c_qmax;
    assign w_qinc      = r_qdepth + 1'b1;
    assign w_cur_addr  = r_addrq[r_qdepth];

    // Without a PLB every level below the top is forced to miss so the whole
    // PosMap chain is looked up, as a plain recursive ORAM would.
    assign w_fake_miss = c_plb_off && r_preparing && i_PPPValid && w_below_top;
    assign w_miss      = i_PPPValid && (!i_PPPHit || w_fake_miss);
    assign w_uninit    = i_PPPValid && i_PPPHit && i_PPPUnInit;

    assign o_CmdInReady = !r_preparing && !r_accessing && !i_ExpectingProgramData
                          && i_PPPCmdReady && !i_FakeAccess;
    assign w_accept     = o_CmdInReady && i_CmdInValid;

    assign w_dbr        = r_accessing && (r_qdepth == '0);
    assign w_init_req   = w_dbr && w_uninit;
    assign o_CmdOutValid = r_accessing && i_PPPValid && !w_err
                           && ((i_PPPHit && !i_PPPUnInit) || w_init_req || i_PPPEvict);
    assign w_fire       = o_CmdOutValid && i_CmdOutReady;
    assign w_switch     = r_accessing && ((w_fire && !i_PPPEvict) || (!w_dbr && w_uninit));

    assign o_DataBlockReq = w_dbr;
    assign o_InitRequest  = w_init_req;
    assign o_SwitchReq    = w_switch;

    always_comb begin
        o_CmdOut   = c_becmd_readrmv;
        o_WMaskOut = '0;
        o_AddrOut  = w_cur_addr;
        if (i_PPPEvict || w_init_req) begin
            o_CmdOut = c_becmd_append;
        end else if (w_dbr) begin
            o_CmdOut   = r_last_cmd;
            o_WMaskOut = r_last_mask;
        end
        if (i_PPPEvict) begin
            o_AddrOut = c_nvb + i_PPPAddrOut / c_lib;
        end
    end

    assign w_refill      = r_accessing && (i_PPPRefillDataValid || r_init_refill);
    assign o_PPPRefill   = w_refill;
    assign o_PPPCmdValid = r_lookup || (w_refill && !r_refill_started);
    assign o_PPPAddrIn   = w_cur_addr;

    always_comb begin
        o_PPPCmd = c_cache_write;
        if (w_refill) begin
            o_PPPCmd = r_init_refill ? c_cache_initrefill : c_cache_refill;
        end else if (r_preparing && c_plb_off && w_below_top) begin
            o_PPPCmd = c_cache_read;
        end
    end

    assign o_PPPOutReady = r_preparing ? w_miss
                         : ((w_miss && !i_PPPEvict) || (w_uninit && r_qdepth != '0) || i_CmdOutReady);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_preparing      <= 1'b0;
            r_accessing      <= 1'b0;
            r_refill_started <= 1'b0;
            r_init_refill    <= 1'b0;
            r_lookup         <= 1'b0;
            r_qdepth         <= '0;
            r_last_cmd       <= '0;
            r_last_mask      <= '0;
            for (int i = 0; i < RECURSION; i++) begin
                r_addrq[i] <= '0;
            end
        end else begin
            if (w_accept) begin
                r_last_cmd  <= i_CmdIn;
                r_last_mask <= i_WMaskIn;
                r_qdepth    <= '0;
                r_addrq[0]  <= i_ProgAddrIn;
            end else if (r_preparing && w_miss && w_below_top) begin
                r_addrq[w_qinc] <= c_nvb + w_cur_addr / c_lib;
                r_qdepth        <= w_qinc;
            end else if (w_switch && r_qdepth != '0) begin
                r_qdepth <= r_qdepth - 1'b1;
            end

            if (r_preparing && i_PPPValid && !w_miss) begin
                r_preparing <= 1'b0;
            end else if (w_accept) begin
                r_preparing <= 1'b1;
            end

            if (w_switch && w_dbr) begin
                r_accessing <= 1'b0;
            end else if (r_preparing && i_PPPValid && !w_miss) begin
                r_accessing <= 1'b1;
            end

            if (w_switch) begin
                r_refill_started <= 1'b0;
            end else if (w_refill && i_PPPCmdReady) begin
                r_refill_started <= 1'b1;
            end

            if (r_init_refill && i_PPPCmdReady) begin
                r_init_refill <= 1'b0;
            end else if (w_switch && !w_dbr && w_uninit) begin
                r_init_refill <= 1'b1;
            end

            if (r_accessing && w_switch) begin
                r_lookup <= 1'b0;
            end else if (w_accept) begin
                r_lookup <= 1'b1;
            end else if (r_preparing) begin
                r_lookup <= w_miss;
            end else begin
                r_lookup <= r_refill_started && i_PPPCmdReady && i_PPPEvictDataEmpty;
            end
        end
    end

`ifdef UORAM_RANGE_CHECK_EN
    logic r_err;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_err <= 1'b0;
        end else if (w_accept && i_ProgAddrIn >= c_nvb) begin
            r_err <= 1'b1;
        end
    end
    assign w_err = r_err;
`else
    assign w_err = 1'b0;
`endif

    assign o_ErrorOutOfRange = w_err;

endmodule
`default_nettype wire

// File: tb/tb_uoram_frontend_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_uoram_frontend_ctrl
// Brief    : Randomised self-checking bench; PLB-enabled and PLB-disabled DUTs.
// Revision : 1.0 - initial release
// ============================================================================
module tb_uoram_frontend_ctrl;

    localparam int NVB = 1024;
    localparam int LIB = 16;
    localparam int REC = 3;

    typedef struct packed {
        logic [1:0]  c;
        logic [31:0] a;
        logic [7:0]  m;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    int   sel = 0;
    int   n_tests = 0;
    int   n_fail = 0;
    exp_t expq[$];

    logic        cmd_in_valid = 0, ppp_cmd_ready = 1, ppp_valid = 0, ppp_hit = 0;
    logic        ppp_uninit = 0, ppp_evict = 0, refill_dv = 0, evict_empty = 1;
    logic        cmd_out_ready = 0, exp_prog = 0, fake_access = 0;
    logic [1:0]  cmd_in = 0;
    logic [31:0] prog_addr = 0, ppp_addr_out = 0;
    logic [7:0]  wmask = 0;

    logic        cir[2], pcv[2], prf[2], pour[2], cov[2], swr[2], dbr[2], ireq[2], err[2];
    logic [1:0]  pcmd[2], cout[2];
    logic [31:0] paddr[2], aout[2];
    logic [7:0]  mout[2];

    for (genvar g = 0; g < 2; g++) begin : g_dut
        uoram_frontend_ctrl #(
            .ORAMU(32), .NUM_VALID_BLOCK(NVB), .LEAF_IN_BLOCK(LIB), .RECURSION(REC),
            .ENABLE_PLB(1 - g), .BECMD_WIDTH(2), .DM_WIDTH(8)
        ) u_dut (
            .clk(clk), .rst_n(rst_n),
            .o_CmdInReady(cir[g]), .i_CmdInValid(cmd_in_valid && sel == g),
            .i_CmdIn(cmd_in), .i_ProgAddrIn(prog_addr), .i_WMaskIn(wmask),
            .i_PPPCmdReady(ppp_cmd_ready), .o_PPPCmdValid(pcv[g]), .o_PPPCmd(pcmd[g]),
            .o_PPPAddrIn(paddr[g]), .o_PPPRefill(prf[g]),
            .i_PPPValid(ppp_valid && sel == g), .i_PPPHit(ppp_hit), .i_PPPUnInit(ppp_uninit),
            .i_PPPEvict(ppp_evict), .i_PPPAddrOut(ppp_addr_out), .o_PPPOutReady(pour[g]),
            .i_PPPRefillDataValid(refill_dv && sel == g), .i_PPPEvictDataEmpty(evict_empty),
            .i_CmdOutReady(cmd_out_ready), .o_CmdOutValid(cov[g]), .o_CmdOut(cout[g]),
            .o_AddrOut(aout[g]), .o_WMaskOut(mout[g]), .o_SwitchReq(swr[g]),
            .o_DataBlockReq(dbr[g]), .o_InitRequest(ireq[g]),
            .i_ExpectingProgramData(exp_prog), .i_FakeAccess(fake_access),
            .o_ErrorOutOfRange(err[g])
        );
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic logic [31:0] posmap_of(input logic [31:0] a);
        return NVB + a / LIB;
    endfunction

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic check_fire(input int d);
        exp_t e;
        check("cmd_valid", cov[d], 1);
        if (expq.size() == 0) begin
            check("exp_queue_empty", 1, 0);
        end else begin
            e = expq.pop_front();
            check("cmd_out", cout[d], e.c);
            check("addr_out", aout[d], e.a);
            check("mask_out", mout[d], e.m);
        end
    endtask

    task automatic check_idle(input int d);
        check("idle_ready", cir[d], 1);
        check("idle_pcv", pcv[d], 0);
        check("idle_cov", cov[d], 0);
        check("idle_err", err[d], 0);
    endtask

    // One full request: misses at levels below h, hit at h, optional eviction
    // at level ev, optional uninitialised data block (un0).
    task automatic do_request(input int d, input logic [31:0] a, input logic [1:0] c,
                              input logic [7:0] m, input int hin, input int ev,
                              input logic [31:0] evaddr, input bit un0);
        logic [31:0] p[REC];
        int h;
        sel = d;
        h = (d == 1) ? REC - 1 : hin;
        p[0] = a;
        for (int k = 1; k < REC; k++) p[k] = posmap_of(p[k-1]);
        expq.delete();
        for (int k = h; k >= 0; k--) begin
            if (ev == k) expq.push_back('{2'd1, posmap_of(evaddr), 8'd0});
            if (k > 0)        expq.push_back('{2'd3, p[k], 8'd0});
            else if (un0)     expq.push_back('{2'd1, p[0], 8'd0});
            else              expq.push_back('{c, p[0], m});
        end

        check_idle(d);
        cmd_in_valid = 1; cmd_in = c; prog_addr = a; wmask = m;
        cyc();
        cmd_in_valid = 0; prog_addr = $urandom;
        for (int k = 0; k <= h; k++) begin
            #1;
            check("lk_valid", pcv[d], 1);
            check("lk_cmd", pcmd[d], (d == 1 && k < REC - 1) ? 1 : 0);
            check("lk_addr", paddr[d], p[k]);
            cyc();
            ppp_valid = 1; ppp_hit = (d == 1) ? 1'b1 : (k == h); ppp_uninit = 0; ppp_evict = 0;
            #1;
            check("lk_outready", pour[d], (k < h) ? 1 : 0);
            cyc();
            if (k < h) ppp_valid = 0;
        end

        for (int k = h; k >= 0; k--) begin
            if (k < h) begin
                refill_dv = 1;
                #1;
                check("rf_refill", prf[d], 1);
                check("rf_valid", pcv[d], 1);
                check("rf_cmd", pcmd[d], 2);
                check("rf_addr", paddr[d], p[k]);
                cyc();
                refill_dv = 0;
                #1;
                check("rf_gap", pcv[d], 0);
                cyc();
                check("relk_valid", pcv[d], 1);
                check("relk_cmd", pcmd[d], 0);
                check("relk_addr", paddr[d], p[k]);
                cyc();
            end
            if (ev == k) begin
                ppp_valid = 1; ppp_hit = 1; ppp_uninit = 0; ppp_evict = 1;
                ppp_addr_out = evaddr; cmd_out_ready = 1;
                #1;
                check_fire(d);
                check("ev_noswitch", swr[d], 0);
                cyc();
                ppp_evict = 0; cmd_out_ready = 0;
            end
            ppp_valid = 1; ppp_hit = 1; ppp_uninit = (k == 0) && un0; cmd_out_ready = 0;
            #1;
            repeat ($urandom_range(2, 0)) begin
                check("stall_valid", cov[d], 1);
                check("stall_noswitch", swr[d], 0);
                cyc();
            end
            cmd_out_ready = 1;
            #1;
            check_fire(d);
            check("switch", swr[d], 1);
            check("dblock", dbr[d], (k == 0) ? 1 : 0);
            check("initreq", ireq[d], (k == 0 && un0) ? 1 : 0);
            check("outready", pour[d], 1);
            cyc();
            ppp_valid = 0; cmd_out_ready = 0; ppp_uninit = 0;
        end
        #1;
        check_idle(d);
        check("exp_drained", expq.size(), 0);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (3) @(posedge clk);
        #1;
        for (int d = 0; d < 2; d++) begin
            check("rst_ready", cir[d], 1);
            check("rst_pcv", pcv[d], 0);
            check("rst_cov", cov[d], 0);
            check("rst_refill", prf[d], 0);
            check("rst_switch", swr[d], 0);
            check("rst_err", err[d], 0);
        end
        rst_n = 1;
        cyc();

        do_request(0, 32'd5, 2'd2, 8'hA5, 0, -1, 0, 1'b0);
        do_request(0, 32'd40, 2'd1, 8'h3C, 1, -1, 0, 1'b0);
        do_request(0, 32'd40, 2'd0, 8'h0F, 1, 0, 32'd48, 1'b0);
        do_request(0, 32'd1023, 2'd2, 8'hFF, 2, 2, 32'd48, 1'b1);
        do_request(1, 32'd77, 2'd1, 8'h11, 0, -1, 0, 1'b0);

        for (int i = 0; i < 30; i++) begin
            int h;
            h = $urandom_range(REC - 1, 0);
            do_request($urandom_range(1, 0), 32'($urandom_range(NVB - 1, 0)),
                       2'($urandom_range(3, 0)), 8'($urandom), h,
                       int'($urandom_range(h + 2, 0)) - 1, $urandom,
                       $urandom_range(3, 0) == 0);
        end

        sel = 0;
        cmd_in_valid = 1; prog_addr = 32'd9;
        cyc();
        cmd_in_valid = 0;
        #1;
        check("midrst_busy", cir[0], 0);
        rst_n = 0;
        #1;
        check("midrst_ready", cir[0], 1);
        check("midrst_pcv", pcv[0], 0);
        @(negedge clk);
        rst_n = 1;
        cyc();

`ifdef UORAM_RANGE_CHECK_EN
        cmd_in_valid = 1; prog_addr = NVB;
        cyc();
        cmd_in_valid = 0;
        cyc();
        ppp_valid = 1; ppp_hit = 1;
        cyc();
        cmd_out_ready = 1;
        repeat (4) begin
            #1;
            check("range_err", err[0], 1);
            check("range_blocked", cov[0], 0);
            cyc();
        end
        ppp_valid = 0; cmd_out_ready = 0;
        rst_n = 0;
        #1;
        check("range_err_cleared", err[0], 0);
        @(negedge clk);
        rst_n = 1;
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
